// File: rtl/core_pkg.sv
// Shared pipeline definitions for the 5-stage RV32I core: sequencing FSM encoding,
// NOP encoding, register-index width and the hazard-control output bundle.
package core_pkg;

  localparam int          REG_IDX_W = 5;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [1:0] ST_RUN      = 2'b00;
  localparam logic [1:0] ST_MEM_WAIT = 2'b01;
  localparam logic [1:0] ST_ERROR    = 2'b10;

  typedef struct packed {
    logic pc_wr;
    logic ifid_wr;
    logic ifid_flush;
    logic idex_wr;
    logic idex_flush;
    logic exmem_wr;
    logic memwb_bubble;
  } pipe_ctl_t;

  localparam pipe_ctl_t CTL_OFF      = '{default: 1'b0};
  localparam pipe_ctl_t CTL_ADVANCE  = '{pc_wr: 1'b1, ifid_wr: 1'b1, ifid_flush: 1'b0,
                                         idex_wr: 1'b1, idex_flush: 1'b0, exmem_wr: 1'b1,
                                         memwb_bubble: 1'b0};
  localparam pipe_ctl_t CTL_FREEZE   = '{pc_wr: 1'b0, ifid_wr: 1'b0, ifid_flush: 1'b0,
                                         idex_wr: 1'b0, idex_flush: 1'b0, exmem_wr: 1'b0,
                                         memwb_bubble: 1'b1};
  localparam pipe_ctl_t CTL_BRANCH   = '{pc_wr: 1'b1, ifid_wr: 1'b1, ifid_flush: 1'b1,
                                         idex_wr: 1'b1, idex_flush: 1'b1, exmem_wr: 1'b1,
                                         memwb_bubble: 1'b0};
  localparam pipe_ctl_t CTL_LOAD_USE = '{pc_wr: 1'b0, ifid_wr: 1'b0, ifid_flush: 1'b0,
                                         idex_wr: 1'b1, idex_flush: 1'b1, exmem_wr: 1'b1,
                                         memwb_bubble: 1'b0};

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  function automatic logic load_use_hit(input logic                 ex_is_load,
                                        input logic [REG_IDX_W-1:0] ex_rd,
                                        input logic [REG_IDX_W-1:0] id_rs1,
                                        input logic [REG_IDX_W-1:0] id_rs2,
                                        input logic                 id_uses_rs2);
    return ex_is_load && (ex_rd != '0) &&
           ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, branch flushes, data-memory wait
// states with a timeout trap, plus stall/flush performance counters.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] ifid_rs1,
  input  logic [REG_IDX_W-1:0] ifid_rs2,
  input  logic                 ifid_use_rs2,
  input  logic                 idex_memr,
  input  logic [REG_IDX_W-1:0] idex_rd,
  input  logic                 ex_br_taken,
  input  logic                 exmem_memr,
  input  logic                 exmem_memw,
  input  logic                 dmem_ready,
  output logic                 pc_wr,
  output logic                 ifid_wr,
  output logic                 ifid_flush,
  output logic                 idex_wr,
  output logic                 idex_flush,
  output logic                 exmem_wr,
  output logic                 memwb_bubble,
  output logic                 err,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  localparam logic [7:0] TIMEOUT_V = 8'(TIMEOUT);

  logic [1:0] state, state_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic       mem_busy;
  logic       load_use;
  logic       br_act;
  pipe_ctl_t  ctl;

  assign mem_busy = (exmem_memr | exmem_memw) & ~dmem_ready;
  assign load_use = load_use_hit(idex_memr, idex_rd, ifid_rs1, ifid_rs2, ifid_use_rs2);

  // While frozen the ID/EX contents do not move, so branch and load-use are simply
  // re-evaluated in the first RUN cycle after release.
  always_comb begin
    ctl       = CTL_ADVANCE;
    state_nxt = state;
    wait_nxt  = wait_cnt;
    br_act    = 1'b0;
    case (state)
      ST_RUN: begin
        if (mem_busy) begin
          ctl       = CTL_FREEZE;
          state_nxt = ST_MEM_WAIT;
          wait_nxt  = 8'd1;
        end else if (ex_br_taken) begin
          ctl    = CTL_BRANCH;
          br_act = 1'b1;
        end else if (load_use) begin
          ctl = CTL_LOAD_USE;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          state_nxt = ST_RUN;
          wait_nxt  = 8'd0;
        end else begin
          ctl      = CTL_FREEZE;
          wait_nxt = wait_cnt + 8'd1;
          if (wait_nxt == TIMEOUT_V)
            state_nxt = ST_ERROR;
        end
      end
      ST_ERROR: begin
        ctl = CTL_FREEZE;
      end
      default: begin
        ctl       = CTL_FREEZE;
        state_nxt = ST_ERROR;
      end
    endcase
    if (rst) begin
      ctl    = CTL_OFF;
      br_act = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_RUN;
      wait_cnt <= 8'd0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (state_nxt == ST_ERROR)
        err <= 1'b1;
    end
  end

  assign pc_wr        = ctl.pc_wr;
  assign ifid_wr      = ctl.ifid_wr;
  assign ifid_flush   = ctl.ifid_flush;
  assign idex_wr      = ctl.idex_wr;
  assign idex_flush   = ctl.idex_flush;
  assign exmem_wr     = ctl.exmem_wr;
  assign memwb_bubble = ctl.memwb_bubble;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (~ctl.pc_wr),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (br_act),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: behavioural reference model compared every cycle,
// plus directed vectors with hand-computed literal expectations.
`timescale 1ns/1ps
module tb_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;
  localparam int SAT     = (1 << CNT_W) - 1;

  // Output bundle order: pc_wr ifid_wr ifid_flush idex_wr idex_flush exmem_wr memwb_bubble err
  localparam logic [7:0] NORM = 8'b1101_0100;
  localparam logic [7:0] LU   = 8'b0001_1100;
  localparam logic [7:0] BR   = 8'b1111_1100;
  localparam logic [7:0] FRZ  = 8'b0000_0010;
  localparam logic [7:0] ERRF = 8'b0000_0011;
  localparam logic [7:0] OFF  = 8'b0000_0000;

  localparam int M_RUN  = 0;
  localparam int M_WAIT = 1;
  localparam int M_ERR  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] ifid_rs1 = '0, ifid_rs2 = '0, idex_rd = '0;
  logic       ifid_use_rs2 = 1'b0, idex_memr = 1'b0, ex_br_taken = 1'b0;
  logic       exmem_memr = 1'b0, exmem_memw = 1'b0, dmem_ready = 1'b0;
  logic       pc_wr, ifid_wr, ifid_flush, idex_wr, idex_flush, exmem_wr, memwb_bubble, err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;

  logic       chk_en = 1'b0;
  logic       lit_valid = 1'b0;
  logic [7:0] lit_ctl = '0;
  int         lit_stall = 0;
  int         lit_flush = 0;
  event       probe_ev;

  int   m_mode = M_RUN;
  int   m_wait = 0;
  logic m_err = 1'b0;
  int   m_stall = 0;
  int   m_flush = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .ifid_rs1     (ifid_rs1),
    .ifid_rs2     (ifid_rs2),
    .ifid_use_rs2 (ifid_use_rs2),
    .idex_memr    (idex_memr),
    .idex_rd      (idex_rd),
    .ex_br_taken  (ex_br_taken),
    .exmem_memr   (exmem_memr),
    .exmem_memw   (exmem_memw),
    .dmem_ready   (dmem_ready),
    .pc_wr        (pc_wr),
    .ifid_wr      (ifid_wr),
    .ifid_flush   (ifid_flush),
    .idex_wr      (idex_wr),
    .idex_flush   (idex_flush),
    .exmem_wr     (exmem_wr),
    .memwb_bubble (memwb_bubble),
    .err          (err),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  function automatic logic model_busy();
    return (exmem_memr || exmem_memw) && !dmem_ready;
  endfunction

  function automatic logic model_load_use();
    if (!idex_memr || idex_rd == 5'd0) return 1'b0;
    if (idex_rd == ifid_rs1) return 1'b1;
    return ifid_use_rs2 && (idex_rd == ifid_rs2);
  endfunction

  // What the pipeline must be told this cycle, given the model's mode and the live inputs.
  function automatic logic [7:0] model_ctl(input int mode, input logic err_q);
    if (rst) return OFF;
    if (mode == M_ERR) return {7'b0000_001, err_q};
    if (mode == M_WAIT) return dmem_ready ? NORM : {7'b0000_001, err_q};
    if (model_busy()) return FRZ;
    if (ex_br_taken) return BR;
    if (model_load_use()) return LU;
    return NORM;
  endfunction

  always @(posedge clk or posedge rst) begin : model_update
    logic [7:0] c;
    if (rst) begin
      m_mode  <= M_RUN;
      m_wait  <= 0;
      m_err   <= 1'b0;
      m_stall <= 0;
      m_flush <= 0;
    end else begin
      c = model_ctl(m_mode, m_err);
      if (!c[7] && m_stall < SAT) m_stall <= m_stall + 1;
      if (m_mode == M_RUN && !model_busy() && ex_br_taken && m_flush < SAT)
        m_flush <= m_flush + 1;
      if (m_mode == M_RUN) begin
        if (model_busy()) begin
          m_mode <= M_WAIT;
          m_wait <= 1;
        end
      end else if (m_mode == M_WAIT) begin
        if (dmem_ready) begin
          m_mode <= M_RUN;
          m_wait <= 0;
        end else begin
          m_wait <= m_wait + 1;
          if (m_wait + 1 == TIMEOUT) begin
            m_mode <= M_ERR;
            m_err  <= 1'b1;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk or probe_ev) begin : compare
    logic [7:0] act;
    if (chk_en) begin
      act = {pc_wr, ifid_wr, ifid_flush, idex_wr, idex_flush, exmem_wr, memwb_bubble, err};
      checkOutput("model_ctl", int'(act), int'(model_ctl(m_mode, m_err)));
      checkOutput("model_stall_cnt", int'(stall_cnt), m_stall);
      checkOutput("model_flush_cnt", int'(flush_cnt), m_flush);
      if (lit_valid) begin
        checkOutput("lit_ctl", int'(act), int'(lit_ctl));
        checkOutput("lit_stall_cnt", int'(stall_cnt), lit_stall);
        checkOutput("lit_flush_cnt", int'(flush_cnt), lit_flush);
      end
    end
  end

  task automatic applyStimulus(input logic memr, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic use2, input logic br,
                               input logic xr, input logic xw, input logic rdy);
    @(posedge clk);
    #1;
    lit_valid    = 1'b0;
    idex_memr    = memr;
    idex_rd      = rd;
    ifid_rs1     = rs1;
    ifid_rs2     = rs2;
    ifid_use_rs2 = use2;
    ex_br_taken  = br;
    exmem_memr   = xr;
    exmem_memw   = xw;
    dmem_ready   = rdy;
  endtask

  task automatic expectLit(input logic [7:0] c, input int s, input int f);
    lit_ctl   = c;
    lit_stall = s;
    lit_flush = f;
    lit_valid = 1'b1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    idle();
    chk_en = 1'b1;
    expectLit(OFF, 0, 0);
    idle(); rst = 1'b0; expectLit(NORM, 0, 0);

    // load-use on rs1: exactly one bubble
    applyStimulus(1, 5, 5, 0, 0, 0, 0, 0, 0); expectLit(LU, 0, 0);
    idle();                                   expectLit(NORM, 1, 0);
    // x0 destination and rs2 gating
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0); expectLit(NORM, 1, 0);
    applyStimulus(1, 7, 0, 7, 0, 0, 0, 0, 0); expectLit(NORM, 1, 0);
    applyStimulus(1, 7, 0, 7, 1, 0, 0, 0, 0); expectLit(LU, 1, 0);
    idle();                                   expectLit(NORM, 2, 0);
    // branch beats load-use
    applyStimulus(1, 5, 5, 0, 0, 1, 0, 0, 0); expectLit(BR, 2, 0);
    idle();                                   expectLit(NORM, 2, 1);
    // three-cycle load wait, release on the fourth
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0); expectLit(FRZ, 2 + i, 1);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1); expectLit(NORM, 5, 1);
    idle();                                   expectLit(NORM, 5, 1);
    // store completing in the same cycle costs nothing
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1); expectLit(NORM, 5, 1);
    // store that never completes: ERROR after TIMEOUT wait cycles
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0); expectLit(FRZ, 5 + i, 1);
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 0, 0, 0, (i == 2), 0, 1, (i > 0));
      expectLit(ERRF, (9 + i > SAT) ? SAT : 9 + i, 1);
    end

    idle(); rst = 1'b1; expectLit(OFF, 0, 0);
    idle(); rst = 1'b0; expectLit(NORM, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0); expectLit(FRZ, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0); expectLit(FRZ, 1, 0);
    // asynchronous reset pulse between clock edges while waiting on memory
    @(negedge clk);
    #1;
    lit_valid = 1'b0;
    rst = 1'b1;
    #1;
    expectLit(OFF, 0, 0);
    -> probe_ev;
    #1;
    lit_valid  = 1'b0;
    rst        = 1'b0;
    exmem_memr = 1'b0;
    #1;
    expectLit(NORM, 0, 0);
    -> probe_ev;
    idle();                                   expectLit(NORM, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0); expectLit(BR, 0, 0);
    idle();                                   expectLit(NORM, 0, 1);

    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RV32I core; companion to the forwarding unit.
- Detects hazards that forwarding cannot resolve:
  - load-use dependencies;
  - taken branches/jumps resolved in EX;
  - multi-cycle data-memory accesses.
- Drives PC / pipeline-register write enables, bubbles and flushes.
- Holds a small wait-state FSM and saturating stall/flush performance counters.

Parameters:
- TIMEOUT, 16: maximum cycles spent in MEM_WAIT before entering ERROR (legal range 2..255).
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- ifid_rs1  in  5  rs1 of the instruction in ID
- ifid_rs2  in  5  rs2 of the instruction in ID
- ifid_use_rs2  in  1  ID instruction reads rs2 (R/S/B types)
- idex_memr  in  1  instruction in EX is a load
- idex_rd  in  5  destination register of the EX instruction
- ex_br_taken  in  1  branch/jump in EX resolved taken
- exmem_memr  in  1  MEM-stage load
- exmem_memw  in  1  MEM-stage store
- dmem_ready  in  1  data memory completes the access this cycle
- pc_wr  out  1  PC write enable
- ifid_wr  out  1  IF/ID register write enable
- ifid_flush  out  1  IF/ID loads NOP
- idex_wr  out  1  ID/EX register write enable
- idex_flush  out  1  ID/EX loads NOP (bubble)
- exmem_wr  out  1  EX/MEM register write enable
- memwb_bubble  out  1  MEM/WB loads NOP (regwrite=0)
- err  out  1  sticky memory-timeout error
- stall_cnt  out  CNT_W  cycles with pc_wr=0, saturating
- flush_cnt  out  CNT_W  branch flushes taken, saturating

Behaviour:
- Reset (async, active-high):
  - state=RUN; wait counter=0; err=0; stall_cnt=0; flush_cnt=0.
  - While rst is high, all write enables=0, all flush/bubble outputs=0.
- FSM states: RUN, MEM_WAIT, ERROR. Control outputs are Mealy (combinational from state + inputs); counters and err are registered.
- mem_busy = (exmem_memr | exmem_memw) & !dmem_ready.
- load_use = idex_memr & (idex_rd != 0) & ((idex_rd == ifid_rs1) | (ifid_use_rs2 & (idex_rd == ifid_rs2))).
- RUN, priority order highest first:
  1. mem_busy: freeze. pc_wr = ifid_wr = idex_wr = exmem_wr = 0; memwb_bubble=1; no flushes. Next state MEM_WAIT; wait counter=1.
  2. ex_br_taken: pc_wr=1, ifid_flush=1, idex_flush=1, all wr=1. flush_cnt+1. A load_use in the same cycle is ignored because the ID instruction is being squashed.
  3. load_use: pc_wr=0, ifid_wr=0, idex_flush=1, idex_wr=1, exmem_wr=1. Exactly one bubble; no re-detection, since EX then holds a NOP.
  4. otherwise: all wr=1, all flush/bubble=0.
- MEM_WAIT:
  - Freeze outputs as in RUN item 1, except when dmem_ready=1 in this cycle. Then: all wr=1, memwb_bubble=0, next state RUN, wait counter cleared.
  - ex_br_taken and load_use are not acted on while frozen. They are re-evaluated in the cycle after release, because the EX/ID contents are unchanged.
  - Wait counter increments each cycle that dmem_ready=0. When it reaches TIMEOUT with dmem_ready still 0: next state ERROR, err<=1.
- ERROR: freeze outputs held permanently; err=1. Exit only by rst.
- stall_cnt increments on every cycle (rst low) with pc_wr=0, saturates at all-ones.
- flush_cnt increments once per RUN cycle where ex_br_taken is acted on, saturates at all-ones.
- A store (exmem_memw) with dmem_ready=1 in the same cycle completes with no stall.
- Reset asserted mid-MEM_WAIT: return to RUN immediately. Counters are cleared (reset, not preserved).

Decomposition:
- Shared pipeline package (core_pkg):
  - FSM state encoding: RUN=2'b00, MEM_WAIT=2'b01, ERROR=2'b10.
  - NOP instruction constant (32'h00000013).
  - Register-index width constant (5).
- One natural sub-module, sat_counter (CNT_W wide, inc enable, async clear): instantiated twice for stall_cnt and flush_cnt.
- FSM and hazard logic stay in hazard_ctrl.

Test Plan:
- Load-use: idex_memr=1, idex_rd=5, ifid_rs1=5 for one cycle, then idex_memr=0 -> exactly one cycle of pc_wr=0, ifid_wr=0, idex_flush=1; stall_cnt=1.
- x0 and rs2 gating:
  - idex_rd=0, idex_memr=1, ifid_rs1=0 -> no stall.
  - idex_rd=7, ifid_rs2=7, ifid_use_rs2=0 -> no stall.
  - same with ifid_use_rs2=1 -> one-cycle stall.
- Branch beats load-use: ex_br_taken=1 with a load_use condition present -> ifid_flush=1, idex_flush=1, pc_wr=1; flush_cnt=1; stall_cnt unchanged.
- Memory wait: exmem_memr=1, dmem_ready=0 for 3 cycles, then 1 -> freeze (memwb_bubble=1, all wr=0) for 3 cycles; release on the 4th; state RUN; stall_cnt=3.
- Timeout: TIMEOUT=4, exmem_memw=1, dmem_ready held 0 -> ERROR entered after 4 wait cycles; err=1 and outputs frozen; dmem_ready=1 later has no effect.
- Async reset mid-MEM_WAIT: pulse rst between clock edges -> err=0, counters=0, state RUN with no clock edge required; normal flow afterwards.
